// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder and the CPU datapath that talks
// to it: default bus widths, the memory-mapped I/O addresses at the top of the
// address space, and the responder state encoding.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    // MMIO locations for the default address width (all-ones and all-ones-1).
    localparam logic [DEF_ADDR_W-1:0] MMIO_LED_ADDR = 8'hFF;
    localparam logic [DEF_ADDR_W-1:0] MMIO_SW_ADDR  = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_ram.sv
// -----------------------------------------------------------------------------
// mem_ram
// Synchronous single-port RAM with write enable and a registered read port,
// written so that it maps onto a block RAM with an output register.
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset, clears only the read register
//   we     in   write enable
//   re     in   read enable; rdata holds between reads
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module mem_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Array contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the multi-cycle CPU control unit. Accepts a held
// MemRead/MemWrite request, waits WAIT_STATES cycles, performs the access on
// the edge leaving the wait phase and pulses MemReady for one cycle.
// Build option: define MEM_MMIO_EN to map an LED register at address all-ones
// and a synchronized switch port at all-ones-1; otherwise both are plain RAM.
// Ports:
//   clock     in   single clock
//   reset     in   async active-low reset
//   MemRead   in   read request, held until MemReady
//   MemWrite  in   write request, held until MemReady (wins over MemRead)
//   Addr      in   word address, sampled at acceptance
//   WrData    in   write data, sampled at acceptance
//   RdData    out  registered read data, valid with MemReady, held until next read
//   MemReady  out  one-cycle registered completion strobe
//   ioSwitch  in   asynchronous switch inputs
//   ioLED     out  LED register (0 when MMIO is disabled)
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              MemReady,
    input  logic [DATA_W-1:0] ioSwitch,
    output logic [DATA_W-1:0] ioLED
);

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic              ready_q;

    logic              req;
    logic              acc_fire;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_q;

    assign req = MemRead | MemWrite;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live bus is used; otherwise the latched request is used. The
    // reset term keeps a request held during reset from touching the RAM.
    always_comb begin
        acc_fire = 1'b0;
        acc_wr   = wr_q;
        acc_addr = addr_q;
        acc_data = data_q;
        if (state_q == ST_IDLE) begin
            acc_wr   = MemWrite;
            acc_addr = Addr;
            acc_data = WrData;
            acc_fire = reset & req & (WAIT_STATES == 0);
        end else if (state_q == ST_WAIT) begin
            acc_fire = reset & (cnt_q == 4'd0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (req) begin
                        addr_q <= Addr;
                        data_q <= WrData;
                        wr_q   <= MemWrite;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WS_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign MemReady = ready_q;

`ifdef MEM_MMIO_EN
    localparam logic [ADDR_W-1:0] LED_A = '1;
    localparam logic [ADDR_W-1:0] SW_A  = {{(ADDR_W-1){1'b1}}, 1'b0};

    logic              is_led;
    logic              is_sw;
    logic              is_mmio;
    logic [DATA_W-1:0] sw_meta_q;
    logic [DATA_W-1:0] sw_sync_q;
    logic [DATA_W-1:0] led_q;
    logic [DATA_W-1:0] mmio_q;
    logic              src_mmio_q;

    assign is_led  = (acc_addr == LED_A);
    assign is_sw   = (acc_addr == SW_A);
    assign is_mmio = is_led | is_sw;
    assign ram_we  = acc_fire &  acc_wr & ~is_mmio;
    assign ram_re  = acc_fire & ~acc_wr & ~is_mmio;

    // RdData comes either from the RAM output register or from mmio_q;
    // src_mmio_q remembers which source the most recent read used.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            led_q      <= '0;
            mmio_q     <= '0;
            src_mmio_q <= 1'b0;
        end else begin
            sw_meta_q <= ioSwitch;
            sw_sync_q <= sw_meta_q;
            if (acc_fire && acc_wr && is_led) begin
                led_q <= acc_data;
            end
            if (acc_fire && !acc_wr) begin
                src_mmio_q <= is_mmio;
                if (is_mmio) begin
                    mmio_q <= is_led ? led_q : sw_sync_q;
                end
            end
        end
    end

    assign RdData = src_mmio_q ? mmio_q : ram_q;
    assign ioLED  = led_q;
`else
    logic unused_sw;

    assign ram_we    = acc_fire &  acc_wr;
    assign ram_re    = acc_fire & ~acc_wr;
    assign RdData    = ram_q;
    assign ioLED     = '0;
    assign unused_sw = ^ioSwitch;
`endif

    mem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clock),
        .rst_n (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (acc_addr),
        .wdata (acc_data),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Three instances share one clock:
//   unit 0: WAIT_STATES=1, unit 1: WAIT_STATES=0, unit 2: WAIT_STATES=3.
// Latency below is counted in falling-edge samples after the acceptance edge;
// MemReady is expected in sample WAIT_STATES+1.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rstn  [3];
    logic       rd    [3];
    logic       wr    [3];
    logic [7:0] addr  [3];
    logic [7:0] wdata [3];
    logic [7:0] sw    [3];
    logic [7:0] rdata [3];
    logic       rdy   [3];
    logic [7:0] led   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(1)) u_ws1 (
        .clock(clk), .reset(rstn[0]), .MemRead(rd[0]), .MemWrite(wr[0]),
        .Addr(addr[0]), .WrData(wdata[0]), .RdData(rdata[0]), .MemReady(rdy[0]),
        .ioSwitch(sw[0]), .ioLED(led[0])
    );

    mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
        .clock(clk), .reset(rstn[1]), .MemRead(rd[1]), .MemWrite(wr[1]),
        .Addr(addr[1]), .WrData(wdata[1]), .RdData(rdata[1]), .MemReady(rdy[1]),
        .ioSwitch(sw[1]), .ioLED(led[1])
    );

    mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(3)) u_ws3 (
        .clock(clk), .reset(rstn[2]), .MemRead(rd[2]), .MemWrite(wr[2]),
        .Addr(addr[2]), .WrData(wdata[2]), .RdData(rdata[2]), .MemReady(rdy[2]),
        .ioSwitch(sw[2]), .ioLED(led[2])
    );

    // Issue one request, hold it until MemReady, drop it after the edge that
    // ends DONE. lat = sample index of MemReady (-1 on timeout), q = RdData then.
    task automatic access(input int u, input logic w, input logic r,
                          input logic [7:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] q);
        bit seen;
        @(posedge clk); #1;
        wr[u] = w; rd[u] = r; addr[u] = a; wdata[u] = d;
        @(posedge clk);
        seen = 1'b0; lat = -1; q = 8'h00;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (rdy[u]) begin
                seen = 1'b1; lat = i; q = rdata[u];
            end
        end
        @(posedge clk); #1;
        wr[u] = 1'b0; rd[u] = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        logic [7:0] q;
        bit pulsed;
        for (int u = 0; u < 3; u++) begin
            n_checks++;
            if (rdy[u] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", u, rdy[u]); end
            n_checks++;
            if (rdata[u] !== 8'h00) begin n_fail++; $display("FAIL reset_rddata[%0d]: got %h expected 00", u, rdata[u]); end
            n_checks++;
            if (led[u] !== 8'h00) begin n_fail++; $display("FAIL reset_led[%0d]: got %h expected 00", u, led[u]); end
        end
        // Seed prior contents of 0x10.
        access(0, 1'b1, 1'b0, 8'h10, 8'h11, lat, q);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL reset_seed_latency: got %0d expected 2", lat); end
        // Write 0x5A to 0x10, reset lands during WAIT.
        @(posedge clk); #1;
        wr[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        rstn[0] = 1'b0;
        wr[0]   = 1'b0;
        pulsed  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rdy[0]) pulsed = 1'b1;
        end
        rstn[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rdy[0]) pulsed = 1'b1;
        end
        n_checks++;
        if (pulsed !== 1'b0) begin n_fail++; $display("FAIL reset_mid_wait_ready: got %b expected 0", pulsed); end
        access(0, 1'b0, 1'b1, 8'h10, 8'h00, lat, q);
        n_checks++;
        if (q !== 8'h11) begin n_fail++; $display("FAIL reset_no_write: got %h expected 11", q); end
    endtask

    task automatic test_write_read();
        int lat;
        logic [7:0] q;
        access(0, 1'b1, 1'b0, 8'h20, 8'h3C, lat, q);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        access(0, 1'b0, 1'b1, 8'h20, 8'h00, lat, q);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        n_checks++;
        if (q !== 8'h3C) begin n_fail++; $display("FAIL rd_data: got %h expected 3c", q); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] q, d0, d1;
        logic [3:0] pat;
        access(1, 1'b1, 1'b0, 8'h00, 8'hC3, lat, q);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL b2b_seed_latency: got %0d expected 1", lat); end
        access(1, 1'b1, 1'b0, 8'h01, 8'h7E, lat, q);
        @(posedge clk); #1;
        rd[1] = 1'b1; addr[1] = 8'h00;
        @(posedge clk);
        @(negedge clk); pat[3] = rdy[1]; d0 = rdata[1];
        @(posedge clk); #1; addr[1] = 8'h01;
        @(negedge clk); pat[2] = rdy[1];
        @(negedge clk); pat[1] = rdy[1]; d1 = rdata[1];
        @(posedge clk); #1; rd[1] = 1'b0;
        @(negedge clk); pat[0] = rdy[1];
        n_checks++;
        if (pat !== 4'b1010) begin n_fail++; $display("FAIL b2b_ready_pattern: got %b expected 1010", pat); end
        n_checks++;
        if (d0 !== 8'hC3) begin n_fail++; $display("FAIL b2b_data0: got %h expected c3", d0); end
        n_checks++;
        if (d1 !== 8'h7E) begin n_fail++; $display("FAIL b2b_data1: got %h expected 7e", d1); end
    endtask

    task automatic test_simultaneous();
        int lat;
        logic [7:0] q;
        access(0, 1'b0, 1'b1, 8'h20, 8'h00, lat, q);
        access(0, 1'b1, 1'b1, 8'h40, 8'hA5, lat, q);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL both_latency: got %0d expected 2", lat); end
        n_checks++;
        if (q !== 8'h3C) begin n_fail++; $display("FAIL both_rddata_held: got %h expected 3c", q); end
        access(0, 1'b0, 1'b1, 8'h40, 8'h00, lat, q);
        n_checks++;
        if (q !== 8'hA5) begin n_fail++; $display("FAIL both_write_done: got %h expected a5", q); end
    endtask

    task automatic test_mmio();
        int lat;
        logic [7:0] q;
        access(0, 1'b1, 1'b0, 8'hFF, 8'h81, lat, q);
`ifdef MEM_MMIO_EN
        n_checks++;
        if (led[0] !== 8'h81) begin n_fail++; $display("FAIL mmio_led: got %h expected 81", led[0]); end
        access(0, 1'b0, 1'b1, 8'hFF, 8'h00, lat, q);
        n_checks++;
        if (q !== 8'h81) begin n_fail++; $display("FAIL mmio_led_read: got %h expected 81", q); end
        sw[0] = 8'h0F;
        repeat (3) @(posedge clk);
        access(0, 1'b0, 1'b1, 8'hFE, 8'h00, lat, q);
        n_checks++;
        if (q !== 8'h0F) begin n_fail++; $display("FAIL mmio_sw_read: got %h expected 0f", q); end
        access(0, 1'b1, 1'b0, 8'hFE, 8'h22, lat, q);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL mmio_sw_write_latency: got %0d expected 2", lat); end
        access(0, 1'b0, 1'b1, 8'hFE, 8'h00, lat, q);
        n_checks++;
        if (q !== 8'h0F) begin n_fail++; $display("FAIL mmio_sw_write_noeffect: got %h expected 0f", q); end
`else
        n_checks++;
        if (led[0] !== 8'h00) begin n_fail++; $display("FAIL ram_led_zero: got %h expected 00", led[0]); end
        access(0, 1'b0, 1'b1, 8'hFF, 8'h00, lat, q);
        n_checks++;
        if (q !== 8'h81) begin n_fail++; $display("FAIL ram_ff_read: got %h expected 81", q); end
        sw[0] = 8'h0F;
        access(0, 1'b1, 1'b0, 8'hFE, 8'h22, lat, q);
        access(0, 1'b0, 1'b1, 8'hFE, 8'h00, lat, q);
        n_checks++;
        if (q !== 8'h22) begin n_fail++; $display("FAIL ram_fe_read: got %h expected 22", q); end
`endif
    endtask

    task automatic test_drop_mid_wait();
        int lat, pulses, pos;
        logic [7:0] q;
        @(posedge clk); #1;
        wr[2] = 1'b1; addr[2] = 8'h50; wdata[2] = 8'h33;
        @(posedge clk);
        pulses = 0; pos = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) wr[2] = 1'b0;
            if (rdy[2]) begin
                pulses++;
                if (pos < 0) pos = i;
            end
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL drop_pulse_count: got %0d expected 1", pulses); end
        n_checks++;
        if (pos !== 4) begin n_fail++; $display("FAIL drop_pulse_pos: got %0d expected 4", pos); end
        access(2, 1'b0, 1'b1, 8'h50, 8'h00, lat, q);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL drop_read_latency: got %0d expected 4", lat); end
        n_checks++;
        if (q !== 8'h33) begin n_fail++; $display("FAIL drop_write_commit: got %h expected 33", q); end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rstn[u] = 1'b0; rd[u] = 1'b0; wr[u] = 1'b0;
            addr[u] = 8'h00; wdata[u] = 8'h00; sw[u] = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) rstn[u] = 1'b1;
        @(negedge clk);

        test_reset();
        test_write_read();
        test_back_to_back();
        test_simultaneous();
        test_mmio();
        test_drop_mid_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
